top_riscv: RTL and testbench



---
 rtl/top_riscv.sv | 166 ++++++++++++++++
 tb/tb_top_riscv.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_riscv.sv
// Five-stage (F/D/E/M/W) RV32I-subset core; instruction ROM and data RAM sit outside.
// Optional RISCV_FORWARD_EN: forward ALU operands from M/W; otherwise dependents stall in D.
module top_riscv #(
    parameter int n = 10,
    parameter int m = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  instrF,
    output logic [n-1:0] addr,
    output logic [m-1:0] write_dataM,
    output logic         memwrM,
    input  logic [31:0]  read_dataM,
    output logic [31:0]  PCF,
    output logic [31:0]  instrD
);
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_LINK} alu_t;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;

    logic [31:0] rf [0:31];
    logic [31:0] pcD, pcE, rd1D, rd2D, rd1E, rd2E, immD, immE;
    logic [31:0] srcAE, srcBE, fwdBE, resE, targetE, aluM, wdM, resultW;
    logic [4:0]  rs1D, rs2D, rdD, rdE, rdM, rdW;
    logic        regwrD, memwrD, loadD, beqD, jalD, alusrcD, use1D, use2D;
    logic        regwrE, memwrE, loadE, beqE, jalE, alusrcE;
    logic        regwrM, loadM, regwrW, stall, takenE, bubble;
    alu_t        aluD, aluE;

    assign rs1D = instrD[19:15];
    assign rs2D = instrD[24:20];
    assign rdD  = instrD[11:7];

    always_comb begin
        regwrD = 1'b0; memwrD = 1'b0; loadD = 1'b0; beqD = 1'b0; jalD = 1'b0;
        alusrcD = 1'b0; use1D = 1'b0; use2D = 1'b0; aluD = ALU_ADD;
        immD = {{20{instrD[31]}}, instrD[31:20]};
        case (instrD[6:0])
            OP_R: begin
                use1D = 1'b1; use2D = 1'b1; regwrD = 1'b1;
                case (instrD[14:12])
                    3'b000:  aluD = instrD[30] ? ALU_SUB : ALU_ADD;
                    3'b111:  aluD = ALU_AND;
                    3'b110:  aluD = ALU_OR;
                    3'b010:  aluD = ALU_SLT;
                    default: regwrD = 1'b0;
                endcase
            end
            OP_I: begin
                use1D = 1'b1; alusrcD = 1'b1; regwrD = 1'b1;
                case (instrD[14:12])
                    3'b000:  aluD = ALU_ADD;
                    3'b111:  aluD = ALU_AND;
                    3'b110:  aluD = ALU_OR;
                    3'b010:  aluD = ALU_SLT;
                    default: regwrD = 1'b0;
                endcase
            end
            OP_LW: begin
                use1D = 1'b1; alusrcD = 1'b1; regwrD = 1'b1; loadD = 1'b1;
            end
            OP_SW: begin
                use1D = 1'b1; use2D = 1'b1; alusrcD = 1'b1; memwrD = 1'b1;
                immD = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
            end
            OP_BEQ: begin
                use1D = 1'b1; use2D = 1'b1; beqD = (instrD[14:12] == 3'b000);
                immD = {{19{instrD[31]}}, instrD[31], instrD[7], instrD[30:25], instrD[11:8], 1'b0};
            end
            OP_JAL: begin
                regwrD = 1'b1; jalD = 1'b1; aluD = ALU_LINK;
                immD = {{11{instrD[31]}}, instrD[31], instrD[19:12], instrD[20], instrD[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    // Write-through so an instruction in D sees the value retiring in W this cycle.
    assign rd1D = (rs1D == 5'd0) ? 32'd0 : (regwrW && rdW == rs1D) ? resultW : rf[rs1D];
    assign rd2D = (rs2D == 5'd0) ? 32'd0 : (regwrW && rdW == rs2D) ? resultW : rf[rs2D];

`ifdef RISCV_FORWARD_EN
    logic [4:0] rs1E, rs2E;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1E <= '0;
            rs2E <= '0;
        end else begin
            rs1E <= rs1D;
            rs2E <= rs2D;
        end
    end
    assign srcAE = (rs1E != 5'd0 && regwrM && rs1E == rdM) ? aluM :
                   (rs1E != 5'd0 && regwrW && rs1E == rdW) ? resultW : rd1E;
    assign fwdBE = (rs2E != 5'd0 && regwrM && rs2E == rdM) ? aluM :
                   (rs2E != 5'd0 && regwrW && rs2E == rdW) ? resultW : rd2E;
    assign stall = loadE && rdE != 5'd0 && ((use1D && rs1D == rdE) || (use2D && rs2D == rdE));
`else
    assign srcAE = rd1E;
    assign fwdBE = rd2E;
    assign stall = (use1D && rs1D != 5'd0 && ((regwrE && rs1D == rdE) || (regwrM && rs1D == rdM))) ||
                   (use2D && rs2D != 5'd0 && ((regwrE && rs2D == rdE) || (regwrM && rs2D == rdM)));
`endif

    assign srcBE   = alusrcE ? immE : fwdBE;
    assign targetE = pcE + immE;
    assign takenE  = jalE || (beqE && srcAE == fwdBE);
    assign bubble  = takenE || stall;

    always_comb begin
        case (aluE)
            ALU_SUB:  resE = srcAE - srcBE;
            ALU_AND:  resE = srcAE & srcBE;
            ALU_OR:   resE = srcAE | srcBE;
            ALU_SLT:  resE = {31'd0, $signed(srcAE) < $signed(srcBE)};
            ALU_LINK: resE = pcE + 32'd4;
            default:  resE = srcAE + srcBE;
        endcase
    end

    // A taken branch in E overrides a stall: redirect and squash D.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PCF <= '0; instrD <= '0; pcD <= '0;
        end else if (takenE) begin
            PCF <= targetE; instrD <= '0; pcD <= '0;
        end else if (!stall) begin
            PCF <= PCF + 32'd4; instrD <= instrF; pcD <= PCF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrE <= 1'b0; memwrE <= 1'b0; loadE <= 1'b0; beqE <= 1'b0; jalE <= 1'b0;
            alusrcE <= 1'b0; aluE <= ALU_ADD; pcE <= '0; rd1E <= '0; rd2E <= '0;
            immE <= '0; rdE <= '0;
        end else begin
            regwrE <= regwrD & ~bubble; memwrE <= memwrD & ~bubble; loadE <= loadD & ~bubble;
            beqE <= beqD & ~bubble; jalE <= jalD & ~bubble;
            alusrcE <= alusrcD; aluE <= aluD; pcE <= pcD; rd1E <= rd1D; rd2E <= rd2D;
            immE <= immD; rdE <= rdD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrM <= 1'b0; memwrM <= 1'b0; loadM <= 1'b0; rdM <= '0; aluM <= '0; wdM <= '0;
            regwrW <= 1'b0; rdW <= '0; resultW <= '0;
        end else begin
            regwrM <= regwrE; memwrM <= memwrE; loadM <= loadE; rdM <= rdE; aluM <= resE; wdM <= fwdBE;
            regwrW <= regwrM; rdW <= rdM; resultW <= loadM ? read_dataM : aluM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (regwrW && rdW != 5'd0) begin
            rf[rdW] <= resultW;
        end
    end

    assign addr        = aluM[n-1:0];
    assign write_dataM = wdM[m-1:0];
endmodule

// File: tb/tb_top_riscv.sv
// Bench for top_riscv: directed programs plus random programs checked against an ISA-level model.
module tb_top_riscv;
    logic        clk, rst;
    logic [31:0] instrF, read_dataM, PCF, instrD, write_dataM;
    logic [9:0]  addr;
    logic        memwrM;

    logic [31:0] rom [0:255];
    logic [31:0] ram [0:255];
    logic [31:0] ram_init [0:255];
    logic [9:0]  dut_a[$], exp_a[$];
    logic [31:0] dut_d[$], exp_d[$];
    int          dut_c[$];
    int          cyc, nvec, nerr;

    top_riscv #(.n(10), .m(32)) dut (
        .clk(clk), .rst(rst), .instrF(instrF), .addr(addr), .write_dataM(write_dataM),
        .memwrM(memwrM), .read_dataM(read_dataM), .PCF(PCF), .instrD(instrD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instrF     = rom[PCF[9:2]];
    assign read_dataM = ram[addr[9:2]];

    always @(posedge clk or posedge rst)
        if (rst) ram <= ram_init;
        else if (memwrM) ram[addr[9:2]] <= write_dataM;

    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else cyc <= cyc + 1;

    always @(negedge clk)
        if (!rst && memwrM) begin
            dut_a.push_back(addr);
            dut_d.push_back(write_dataM);
            dut_c.push_back(cyc);
        end

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] i_type(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [4:0] rs1, input logic [4:0] rs2);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] j_type(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return i_type(7'b0010011, 3'b000, rd, rs1, imm);
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            rom[i] = 32'd0;
            ram_init[i] = 32'd0;
        end
    endtask

    task automatic run_prog(input int cycles);
        dut_a.delete(); dut_d.delete(); dut_c.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (cycles) @(negedge clk);
        #1;
    endtask

    // Sequential ISA interpreter; records every store in program order.
    task automatic run_model(input int plen);
        logic [31:0] x [0:31];
        logic [31:0] mem [0:255];
        logic [31:0] pc, npc, ins, a, b, res, ea, immi, imms, immb, immj;
        logic        wr;
        exp_a.delete(); exp_d.delete();
        for (int i = 0; i < 32; i++) x[i] = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = ram_init[i];
        pc = 32'd0;
        for (int step = 0; step < 1000 && pc < 32'(4 * plen); step++) begin
            ins  = rom[pc[9:2]];
            a    = x[ins[19:15]];
            b    = x[ins[24:20]];
            immi = {{20{ins[31]}}, ins[31:20]};
            imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            immb = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            immj = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            wr = 1'b0; res = 32'd0; npc = pc + 32'd4;
            case (ins[6:0])
                7'b0110011: begin
                    wr = 1'b1;
                    case ({ins[31:25], ins[14:12]})
                        10'b0000000_000: res = a + b;
                        10'b0100000_000: res = a - b;
                        10'b0000000_111: res = a & b;
                        10'b0000000_110: res = a | b;
                        10'b0000000_010: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: wr = 1'b0;
                    endcase
                end
                7'b0010011: begin
                    wr = 1'b1;
                    case (ins[14:12])
                        3'b000:  res = a + immi;
                        3'b111:  res = a & immi;
                        3'b110:  res = a | immi;
                        3'b010:  res = ($signed(a) < $signed(immi)) ? 32'd1 : 32'd0;
                        default: wr = 1'b0;
                    endcase
                end
                7'b0000011: begin ea = a + immi; wr = 1'b1; res = mem[ea[9:2]]; end
                7'b0100011: begin
                    ea = a + imms;
                    mem[ea[9:2]] = b;
                    exp_a.push_back(ea[9:0]);
                    exp_d.push_back(b);
                end
                7'b1100011: if (ins[14:12] == 3'b000 && a == b) npc = pc + immb;
                7'b1101111: begin wr = 1'b1; res = pc + 32'd4; npc = pc + immj; end
                default: ;
            endcase
            if (wr && ins[11:7] != 5'd0) x[ins[11:7]] = res;
            pc = npc;
        end
    endtask

    task automatic test_reset();
        clear_mem();
        rom[0] = addi(5'd1, 5'd0, 12'd2);
        rst = 1'b1;
        @(negedge clk);
        nvec += 3;
        if (PCF !== 32'd0)    begin nerr++; $display("FAIL reset_pc: got %h want 0", PCF); end
        if (memwrM !== 1'b0)  begin nerr++; $display("FAIL reset_memwr: got %b want 0", memwrM); end
        if (instrD !== 32'd0) begin nerr++; $display("FAIL reset_instrD: got %h want 0", instrD); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        nvec += 2;
        if (PCF !== 32'd4)   begin nerr++; $display("FAIL release_pc: got %h want 4", PCF); end
        if (instrD !== rom[0]) begin nerr++; $display("FAIL release_instrD: got %h want %h", instrD, rom[0]); end
    endtask

    task automatic test_stores();
        clear_mem();
        rom[0] = addi(5'd1, 5'd0, 12'd2);
        rom[1] = s_type(12'd96, 5'd1, 5'd0);
        rom[2] = addi(5'd2, 5'd1, 12'd2);
        rom[3] = s_type(12'd92, 5'd2, 5'd0);
        run_prog(40);
        nvec++;
        if (dut_a.size() != 2) begin
            nerr++; $display("FAIL stores_count: got %0d want 2", dut_a.size());
        end else begin
            nvec += 2;
            if (dut_a[0] !== 10'd96 || dut_d[0] !== 32'd2) begin
                nerr++; $display("FAIL store0: got addr=%0d data=%0d want addr=96 data=2", dut_a[0], dut_d[0]);
            end
            if (dut_a[1] !== 10'd92 || dut_d[1] !== 32'd4) begin
                nerr++; $display("FAIL store1: got addr=%0d data=%0d want addr=92 data=4", dut_a[1], dut_d[1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_mem();
        rom[0] = addi(5'd3, 5'd0, 12'd5);
        rom[1] = r_type(7'h00, 3'b000, 5'd4, 5'd3, 5'd3);
        rom[2] = s_type(12'd0, 5'd4, 5'd0);
        run_prog(40);
        nvec++;
        if (dut_a.size() != 1) begin
            nerr++; $display("FAIL b2b_count: got %0d want 1", dut_a.size());
        end else begin
            nvec += 2;
            if (dut_a[0] !== 10'd0 || dut_d[0] !== 32'd10) begin
                nerr++; $display("FAIL b2b_store: got addr=%0d data=%0d want addr=0 data=10", dut_a[0], dut_d[0]);
            end
`ifdef RISCV_FORWARD_EN
            if (dut_c[0] != 5) begin nerr++; $display("FAIL b2b_cycle: got %0d want 5", dut_c[0]); end
`else
            if (dut_c[0] < 7) begin nerr++; $display("FAIL b2b_cycle: got %0d want >=7", dut_c[0]); end
`endif
        end
    endtask

    task automatic test_load_use();
        clear_mem();
        ram_init[24] = 32'd2;
        rom[0] = i_type(7'b0000011, 3'b010, 5'd5, 5'd0, 12'd96);
        rom[1] = r_type(7'h00, 3'b000, 5'd6, 5'd5, 5'd5);
        rom[2] = s_type(12'd4, 5'd6, 5'd0);
        run_prog(40);
        nvec++;
        if (dut_a.size() != 1) begin
            nerr++; $display("FAIL lu_count: got %0d want 1", dut_a.size());
        end else begin
            nvec++;
            if (dut_a[0] !== 10'd4 || dut_d[0] !== 32'd4) begin
                nerr++; $display("FAIL lu_store: got addr=%0d data=%0d want addr=4 data=4", dut_a[0], dut_d[0]);
            end
`ifdef RISCV_FORWARD_EN
            nvec++;
            if (dut_c[0] != 6) begin nerr++; $display("FAIL lu_cycle: got %0d want 6", dut_c[0]); end
`endif
        end
    endtask

    task automatic test_branch();
        clear_mem();
        rom[0] = b_type(13'd8, 5'd0, 5'd0);
        rom[1] = s_type(12'd0, 5'd1, 5'd0);
        rom[2] = addi(5'd1, 5'd0, 12'd7);
        rom[3] = s_type(12'd12, 5'd1, 5'd0);
        run_prog(3);
        nvec++;
        if (PCF !== 32'd8) begin nerr++; $display("FAIL br_target: got %h want 8", PCF); end
        repeat (30) @(negedge clk);
        #1;
        nvec++;
        if (dut_a.size() != 1) begin
            nerr++; $display("FAIL br_count: got %0d want 1", dut_a.size());
        end else begin
            nvec++;
            if (dut_a[0] !== 10'd12 || dut_d[0] !== 32'd7) begin
                nerr++; $display("FAIL br_store: got addr=%0d data=%0d want addr=12 data=7", dut_a[0], dut_d[0]);
            end
        end
    endtask

    task automatic test_x0();
        clear_mem();
        rom[0] = addi(5'd1, 5'd0, 12'd3);
        rom[1] = addi(5'd0, 5'd1, 12'd9);
        rom[2] = r_type(7'h00, 3'b000, 5'd0, 5'd1, 5'd1);
        rom[3] = s_type(12'd8, 5'd0, 5'd0);
        run_prog(40);
        nvec++;
        if (dut_a.size() != 1 || dut_a[0] !== 10'd8 || dut_d[0] !== 32'd0) begin
            nerr++; $display("FAIL x0_store: got %0d stores first data=%0d want 1 store addr=8 data=0",
                             dut_a.size(), (dut_d.size() > 0) ? dut_d[0] : 32'hx);
        end
    endtask

    task automatic test_midreset();
        int t;
        clear_mem();
        rom[0] = addi(5'd1, 5'd0, 12'd1);
        for (int i = 1; i < 20; i++) rom[i] = s_type(12'(4 * i), 5'd1, 5'd0);
        run_prog(0);
        t = 0;
        while (memwrM !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        nvec++;
        if (memwrM !== 1'b1) begin nerr++; $display("FAIL midrst_wait: memwrM=%b want 1 within 50 cycles", memwrM); end
        #2 rst = 1'b1;
        #1;
        nvec += 3;
        if (memwrM !== 1'b0)  begin nerr++; $display("FAIL midrst_memwr: got %b want 0", memwrM); end
        if (PCF !== 32'd0)    begin nerr++; $display("FAIL midrst_pc: got %h want 0", PCF); end
        if (instrD !== 32'd0) begin nerr++; $display("FAIL midrst_instrD: got %h want 0", instrD); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        nvec++;
        if (PCF !== 32'd4) begin nerr++; $display("FAIL midrst_restart: got %h want 4", PCF); end
    endtask

    task automatic test_random(input int prog);
        int          ni, plen;
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm, off;
        clear_mem();
        for (int i = 0; i < 256; i++) ram_init[i] = $urandom;
        ni = int'($urandom_range(28, 16));
        for (int i = 0; i < ni; i++) begin
            rd  = 5'($urandom_range(7, 0));
            rs1 = 5'($urandom_range(7, 0));
            rs2 = 5'($urandom_range(7, 0));
            imm = 12'($urandom);
            off = 12'(4 * $urandom_range(31, 0));
            case ($urandom_range(13, 0))
                0:  rom[i] = r_type(7'h00, 3'b000, rd, rs1, rs2);
                1:  rom[i] = r_type(7'h20, 3'b000, rd, rs1, rs2);
                2:  rom[i] = r_type(7'h00, 3'b111, rd, rs1, rs2);
                3:  rom[i] = r_type(7'h00, 3'b110, rd, rs1, rs2);
                4:  rom[i] = r_type(7'h00, 3'b010, rd, rs1, rs2);
                5:  rom[i] = i_type(7'b0010011, 3'b000, rd, rs1, imm);
                6:  rom[i] = i_type(7'b0010011, 3'b111, rd, rs1, imm);
                7:  rom[i] = i_type(7'b0010011, 3'b110, rd, rs1, imm);
                8:  rom[i] = i_type(7'b0010011, 3'b010, rd, rs1, imm);
                9:  rom[i] = i_type(7'b0000011, 3'b010, rd, 5'd0, off);
                10: rom[i] = s_type(off, rs2, 5'd0);
                11: rom[i] = b_type(($urandom_range(1, 0) != 0) ? 13'd8 : 13'd12, rs1, rs2);
                12: rom[i] = j_type(($urandom_range(1, 0) != 0) ? 21'd8 : 21'd12, rd);
                default: rom[i] = {20'($urandom), rd, 7'b0110111};
            endcase
        end
        for (int r = 1; r <= 7; r++) rom[ni + r - 1] = s_type(12'(124 + 4 * r), 5'(r), 5'd0);
        plen = ni + 7;
        run_model(plen);
        run_prog(plen * 6 + 20);
        nvec++;
        if (dut_a.size() != exp_a.size()) begin
            nerr++; $display("FAIL rand%0d_count: got %0d stores want %0d", prog, dut_a.size(), exp_a.size());
        end
        for (int i = 0; i < exp_a.size() && i < dut_a.size(); i++) begin
            nvec++;
            if (dut_a[i] !== exp_a[i] || dut_d[i] !== exp_d[i]) begin
                nerr++;
                $display("FAIL rand%0d_store%0d: got addr=%0d data=%h want addr=%0d data=%h",
                         prog, i, dut_a[i], dut_d[i], exp_a[i], exp_d[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        nvec = 0;
        nerr = 0;
        clear_mem();
        test_reset();
        test_stores();
        test_back_to_back();
        test_load_use();
        test_branch();
        test_x0();
        test_midreset();
        for (int p = 0; p < 8; p++) test_random(p);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
